// File: rtl/mul_div_queue_ctrl.sv
// Issue-queue control for the shared mul/div unit: tracks slot occupancy and operand
// readiness, issues the oldest ready entry and drives the slot-register load controls.
module mul_div_queue_ctrl #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               disp_valid,
   output logic               disp_ready,
   input  logic [TAG_W-1:0]   disp_op1_tag,
   input  logic               disp_op1_valid,
   input  logic [TAG_W-1:0]   disp_op2_tag,
   input  logic               disp_op2_valid,
   input  logic               cdb_valid,
   input  logic [TAG_W-1:0]   cdb_tag,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [IDX_W-1:0]   issue_idx,
   output logic [DEPTH-1:0]   slot_we,
   output logic [DEPTH-1:0]   slot_src_disp,
   output logic [DEPTH-1:0]   slot_updt_cmn,
   output logic [DEPTH-1:0]   slot_updt_op1,
   output logic [DEPTH-1:0]   slot_updt_op1_cdb,
   output logic [DEPTH-1:0]   slot_updt_op2,
   output logic [DEPTH-1:0]   slot_updt_op2_cdb,
   output logic [IDX_W:0]     count
);

   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [DEPTH-1:0]   v1_q, v1_d;
   logic [DEPTH-1:0]   v2_q, v2_d;
   logic [TAG_W-1:0]   t1_q [DEPTH];
   logic [TAG_W-1:0]   t1_d [DEPTH];
   logic [TAG_W-1:0]   t2_q [DEPTH];
   logic [TAG_W-1:0]   t2_d [DEPTH];
   logic [IDX_W:0]     count_q, count_d;

   logic [DEPTH-1:0]   rdy_s;
   logic               found_s;
   logic [IDX_W-1:0]   sel_s;
   logic               fire_s;
   logic               dacc_s;
   logic               cdb_ok_s;
   logic               cap1_s, cap2_s;
   logic               mv_s;
   logic [IDX_W:0]     dslot_s;
   int                 dst;

   assign count = count_q;

   always_comb begin
      vld_d             = '0;
      v1_d              = v1_q;
      v2_d              = v2_q;
      t1_d              = t1_q;
      t2_d              = t2_q;
      slot_we           = '0;
      slot_src_disp     = '0;
      slot_updt_cmn     = '0;
      slot_updt_op1     = '0;
      slot_updt_op1_cdb = '0;
      slot_updt_op2     = '0;
      slot_updt_op2_cdb = '0;
      cap1_s            = 1'b0;
      cap2_s            = 1'b0;
      mv_s              = 1'b0;
      dst               = 0;

      rdy_s   = vld_q & v1_q & v2_q;
      found_s = 1'b0;
      sel_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found_s && rdy_s[i]) begin
            found_s = 1'b1;
            sel_s   = IDX_W'(i);
         end
      end
      fire_s     = found_s & issue_ready;
      disp_ready = (count_q < (IDX_W+1)'(DEPTH));
      dacc_s     = disp_valid & disp_ready;
      cdb_ok_s   = cdb_valid & ~flush;

      // Surviving entries shift down past the fired slot; wakeups land on the destination.
      for (int j = 0; j < DEPTH; j++) begin
         if (vld_q[j] && !(fire_s && j == int'(sel_s))) begin
            mv_s       = fire_s && (j > int'(sel_s));
            dst        = mv_s ? j - 1 : j;
            vld_d[dst] = 1'b1;
            t1_d[dst]  = t1_q[j];
            t2_d[dst]  = t2_q[j];
            v1_d[dst]  = v1_q[j];
            v2_d[dst]  = v2_q[j];
            if (mv_s) begin
               slot_we[dst]       = 1'b1;
               slot_updt_cmn[dst] = 1'b1;
               slot_updt_op1[dst] = 1'b1;
               slot_updt_op2[dst] = 1'b1;
            end
            if (cdb_ok_s && !v1_q[j] && t1_q[j] == cdb_tag) begin
               slot_we[dst]           = 1'b1;
               slot_updt_op1[dst]     = 1'b1;
               slot_updt_op1_cdb[dst] = 1'b1;
               v1_d[dst]              = 1'b1;
            end
            if (cdb_ok_s && !v2_q[j] && t2_q[j] == cdb_tag) begin
               slot_we[dst]           = 1'b1;
               slot_updt_op2[dst]     = 1'b1;
               slot_updt_op2_cdb[dst] = 1'b1;
               v2_d[dst]              = 1'b1;
            end
         end
      end

      dslot_s = count_q - (IDX_W+1)'(fire_s);
      if (dacc_s && !flush) begin
         cap1_s = cdb_ok_s & ~disp_op1_valid & (disp_op1_tag == cdb_tag);
         cap2_s = cdb_ok_s & ~disp_op2_valid & (disp_op2_tag == cdb_tag);
         vld_d[dslot_s[IDX_W-1:0]]             = 1'b1;
         t1_d[dslot_s[IDX_W-1:0]]              = disp_op1_tag;
         t2_d[dslot_s[IDX_W-1:0]]              = disp_op2_tag;
         v1_d[dslot_s[IDX_W-1:0]]              = disp_op1_valid | cap1_s;
         v2_d[dslot_s[IDX_W-1:0]]              = disp_op2_valid | cap2_s;
         slot_we[dslot_s[IDX_W-1:0]]           = 1'b1;
         slot_src_disp[dslot_s[IDX_W-1:0]]     = 1'b1;
         slot_updt_cmn[dslot_s[IDX_W-1:0]]     = 1'b1;
         slot_updt_op1[dslot_s[IDX_W-1:0]]     = 1'b1;
         slot_updt_op2[dslot_s[IDX_W-1:0]]     = 1'b1;
         slot_updt_op1_cdb[dslot_s[IDX_W-1:0]] = cap1_s;
         slot_updt_op2_cdb[dslot_s[IDX_W-1:0]] = cap2_s;
      end else begin
         cap1_s = 1'b0;
         cap2_s = 1'b0;
      end

      count_d = count_q + (IDX_W+1)'(dacc_s) - (IDX_W+1)'(fire_s);
      if (flush) begin
         vld_d   = '0;
         count_d = '0;
      end else begin
         vld_d   = vld_d;
      end

      issue_valid = found_s;
      issue_idx   = sel_s;
      // Keep the slot controls quiet while reset is held, whatever the inputs do.
      if (!rst) begin
         issue_valid       = 1'b0;
         issue_idx         = '0;
         slot_we           = '0;
         slot_src_disp     = '0;
         slot_updt_cmn     = '0;
         slot_updt_op1     = '0;
         slot_updt_op1_cdb = '0;
         slot_updt_op2     = '0;
         slot_updt_op2_cdb = '0;
      end else begin
         issue_idx         = sel_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q   <= '0;
         v1_q    <= '0;
         v2_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            t1_q[i] <= '0;
            t2_q[i] <= '0;
         end
      end else begin
         vld_q   <= vld_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            t1_q[i] <= t1_d[i];
            t2_q[i] <= t2_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mul_div_queue_ctrl.sv
// Directed and random checks of mul_div_queue_ctrl against a queue-based reference model.
module tb_mul_div_queue_ctrl;

   localparam int DEPTH = 4;
   localparam int TAG_W = 6;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             disp_valid = 1'b0;
   logic             disp_ready;
   logic [TAG_W-1:0] disp_op1_tag = '0;
   logic             disp_op1_valid = 1'b0;
   logic [TAG_W-1:0] disp_op2_tag = '0;
   logic             disp_op2_valid = 1'b0;
   logic             cdb_valid = 1'b0;
   logic [TAG_W-1:0] cdb_tag = '0;
   logic             issue_valid;
   logic             issue_ready = 1'b0;
   logic [IDX_W-1:0] issue_idx;
   logic [DEPTH-1:0] slot_we, slot_src_disp, slot_updt_cmn, slot_updt_op1;
   logic [DEPTH-1:0] slot_updt_op1_cdb, slot_updt_op2, slot_updt_op2_cdb;
   logic [IDX_W:0]   count;

   mul_div_queue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_op1_tag(disp_op1_tag), .disp_op1_valid(disp_op1_valid),
      .disp_op2_tag(disp_op2_tag), .disp_op2_valid(disp_op2_valid),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_idx(issue_idx),
      .slot_we(slot_we), .slot_src_disp(slot_src_disp), .slot_updt_cmn(slot_updt_cmn),
      .slot_updt_op1(slot_updt_op1), .slot_updt_op1_cdb(slot_updt_op1_cdb),
      .slot_updt_op2(slot_updt_op2), .slot_updt_op2_cdb(slot_updt_op2_cdb),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit [TAG_W-1:0] t1;
      bit             v1;
      bit [TAG_W-1:0] t2;
      bit             v2;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, compare every output against the model at the falling edge, then advance.
   task automatic cycle(input bit dv, input int t1, input bit v1, input int t2, input bit v2,
                        input bit cv, input int ct, input bit ir, input bit fl);
      ent_t nq[$];
      ent_t e;
      bit   found, fire, dacc, moved, c1, c2;
      int   k, p;
      bit [3:0] we, sd, cm, o1, o1c, o2, o2c;
      disp_valid = dv; disp_op1_tag = TAG_W'(t1); disp_op1_valid = v1;
      disp_op2_tag = TAG_W'(t2); disp_op2_valid = v2;
      cdb_valid = cv; cdb_tag = TAG_W'(ct); issue_ready = ir; flush = fl;
      @(negedge clk);
      found = 0; k = 0;
      foreach (q[j]) if (!found && q[j].v1 && q[j].v2) begin found = 1; k = j; end
      fire = found && ir;
      dacc = dv && (q.size() < DEPTH);
      we = 0; sd = 0; cm = 0; o1 = 0; o1c = 0; o2 = 0; o2c = 0;
      foreach (q[j]) begin
         if (fire && j == k) continue;
         e = q[j];
         p = nq.size();
         moved = (p != j);
         if (moved) begin we[p] = 1; cm[p] = 1; o1[p] = 1; o2[p] = 1; end
         if (!fl && cv && !e.v1 && e.t1 == TAG_W'(ct)) begin we[p] = 1; o1[p] = 1; o1c[p] = 1; e.v1 = 1; end
         if (!fl && cv && !e.v2 && e.t2 == TAG_W'(ct)) begin we[p] = 1; o2[p] = 1; o2c[p] = 1; e.v2 = 1; end
         nq.push_back(e);
      end
      if (dacc && !fl) begin
         p = nq.size();
         c1 = cv && !v1 && (t1 == ct);
         c2 = cv && !v2 && (t2 == ct);
         we[p] = 1; sd[p] = 1; cm[p] = 1; o1[p] = 1; o2[p] = 1; o1c[p] = c1; o2c[p] = c2;
         e.t1 = TAG_W'(t1); e.v1 = v1 | c1; e.t2 = TAG_W'(t2); e.v2 = v2 | c2;
         nq.push_back(e);
      end
      if (fl) nq.delete();
      chk("count", 32'(count), 32'(q.size()));
      chk("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
      chk("issue_valid", 32'(issue_valid), 32'(found));
      chk("issue_idx", 32'(issue_idx), 32'(k));
      chk("slot_we", 32'(slot_we), 32'(we));
      chk("slot_src_disp", 32'(slot_src_disp), 32'(sd));
      chk("slot_updt_cmn", 32'(slot_updt_cmn), 32'(cm));
      chk("slot_updt_op1", 32'(slot_updt_op1), 32'(o1));
      chk("slot_updt_op1_cdb", 32'(slot_updt_op1_cdb), 32'(o1c));
      chk("slot_updt_op2", 32'(slot_updt_op2), 32'(o2));
      chk("slot_updt_op2_cdb", 32'(slot_updt_op2_cdb), 32'(o2c));
      q = nq;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with a dispatch pending: controls must stay quiet.
      disp_valid = 1'b1;
      #3;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
      chk("rst_slot_we", 32'(slot_we), 32'd0);
      disp_valid = 1'b0;
      #9 rst = 1'b1;
      @(posedge clk); #1;

      // Fill with ready entries, then one ignored dispatch while full.
      for (int i = 0; i < 5; i++) cycle(1, i, 1, i + 10, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Flush with a dispatch while full.
      cycle(1, 1, 1, 1, 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Oldest entry blocked on tag 5; entry 1 issues and entry 2 collapses down.
      cycle(1, 5, 0, 2, 1, 0, 0, 0, 0);
      cycle(1, 6, 1, 7, 1, 0, 0, 0, 0);
      cycle(1, 8, 1, 9, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Entry 0 fires while entry 1 moves down and wakes on tag 9.
      cycle(1, 1, 1, 2, 1, 0, 0, 0, 0);
      cycle(1, 3, 1, 9, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 9, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // count=2, dispatch captures op1 from the CDB while slot 0 fires.
      cycle(1, 1, 1, 2, 1, 0, 0, 0, 0);
      cycle(1, 7, 1, 8, 1, 0, 0, 0, 0);
      cycle(1, 3, 0, 4, 1, 1, 3, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Asynchronous reset in the middle of a cycle with three entries.
      for (int i = 0; i < 3; i++) cycle(1, i, 0, i, 1, 0, 0, 0, 0);
      disp_valid = 1'b1;
      #3 rst = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_issue_valid", 32'(issue_valid), 32'd0);
      chk("arst_disp_ready", 32'(disp_ready), 32'd1);
      chk("arst_slot_we", 32'(slot_we), 32'd0);
      q.delete();
      disp_valid = 1'b0;
      #3 rst = 1'b1;
      @(posedge clk); #1;

      // Random traffic with a small tag space so wakeups and captures happen often.
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 31) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_div_queue_ctrl.md
Name: mul_div_queue_ctrl

Overview:
- Control and scheduling FSM for the multiply/divide issue queue.
- Drives DEPTH stacked mul/div reservation register slots. Slot 0 holds the oldest entry and the highest occupied index holds the newest.
- Tracks occupancy and operand readiness, and matches CDB broadcast tags against the operand tags it waits on.
- Issues the oldest fully-ready entry to the shared mul/div unit over a valid/ready handshake, then collapses the queue toward slot 0.

Parameters:
- DEPTH, 4: number of reservation slots, a power of 2, at least 2.
- TAG_W, 6: width of the ROB/physical tag.
- IDX_W, $clog2(DEPTH): width of the slot index.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- disp_valid  in  1  dispatch presents a new mul/div instruction.
- disp_ready  out  1  queue can accept a dispatch this cycle.
- disp_op1_tag  in  TAG_W  op1 producer tag.
- disp_op1_valid  in  1  op1 data already valid.
- disp_op2_tag  in  TAG_W  op2 producer tag.
- disp_op2_valid  in  1  op2 data already valid.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  tag of the CDB result.
- issue_valid  out  1  an oldest-ready entry is presented to the mul/div unit.
- issue_ready  in  1  mul/div unit accepts.
- issue_idx  out  IDX_W  slot whose data is routed to the unit.
- slot_we  out  DEPTH  per-slot write enable.
- slot_src_disp  out  DEPTH  1 means the slot loads from the dispatch bus; 0 means it loads from slot i+1.
- slot_updt_cmn  out  DEPTH  load the tag/funct3 block.
- slot_updt_op1  out  DEPTH  load op1.
- slot_updt_op1_cdb  out  DEPTH  op1 is taken from the CDB.
- slot_updt_op2  out  DEPTH  load op2.
- slot_updt_op2_cdb  out  DEPTH  op2 is taken from the CDB.
- count  out  IDX_W+1  occupied slots.

Behaviour:
- Internal state per slot i: vld[i], t1[i], v1[i], t2[i], v2[i]. The slot is ready when vld & v1 & v2.
- Occupied slots are always contiguous, indices 0..count-1.
- Reset (rst=0, asynchronous):
  - vld, v1 and v2 go to 0; count goes to 0.
  - All slot_* vectors and issue_valid go to 0; disp_ready goes to 1.
- Issue select (combinational from state):
  - issue_idx is the lowest index i with a ready slot; issue_valid=1 when any slot is ready.
  - When no slot is ready, issue_idx=0.
  - fire = issue_valid & issue_ready.
- disp_ready = (count < DEPTH). It does not depend on fire, so there is no combinational path from issue_ready. A dispatch while full is ignored. dacc = disp_valid & disp_ready.
- Collapse on fire at index k: for every j > k with vld[j], slot j-1 takes slot j.
  - slot_we[j-1]=1, slot_src_disp[j-1]=0, slot_updt_cmn, slot_updt_op1 and slot_updt_op2 all 1.
  - The state moves down, and vld[count-1] clears.
- Dispatch write: target slot d = count - fire.
  - slot_we[d]=1, slot_src_disp[d]=1, updt_cmn/op1/op2 =1.
  - The slot stores the dispatch tags and valids, and vld[d] is set.
- CDB wakeup applies to every surviving entry after remap to its destination slot (j, or j-1 when it shifts).
  - If cdb_valid & !vX & tX==cdb_tag: slot_updt_opX=1, slot_updt_opX_cdb=1 on the destination slot, slot_we=1, and vX is set.
  - A non-moving entry gets only the op-update bits; slot_updt_cmn=0.
- Dispatch and CDB in the same cycle: if disp_opX_valid=0 and disp_opX_tag==cdb_tag with cdb_valid, the operand captures from the CDB (updt_opX_cdb=1) and enters valid.
- The entry that fires in a cycle is not updated. Its slot is overwritten by the collapse or cleared.
- count_next = count + dacc - fire. Simultaneous dispatch and fire when full is not possible because disp_ready=0 when full.
- flush: all vld clear and count=0 next cycle. flush overrides dispatch and CDB. issue_valid is still evaluated from current state during the flush cycle, and fire is allowed.
- Reset mid-operation discards all entries immediately.

Test Plan:
- Reset, then dispatch 4 entries with both operands valid and issue_ready=0 → count=4, disp_ready=0, issue_valid=1, issue_idx=0; a 5th dispatch is ignored.
- Entry0 waiting on op1 tag 5, entry1 ready, issue_ready=1 → issue_idx=1 fires. Entry0 stays at slot 0; slot_we=0010 with src_disp=0 from slot 2 only if occupied; count decrements.
- Entry1 waiting on op2 tag 9 while entry0 fires, and cdb_valid with cdb_tag=9 in the same cycle → slot_we[0]=1, slot_updt_cmn[0]=1, slot_updt_op2_cdb[0]=1; the next cycle slot 0 is ready and issue_idx=0.
- count=2, dispatch with op1 tag 3 invalid, cdb_tag=3 valid, simultaneous fire of slot 0 → dispatch lands in slot 1 with updt_op1_cdb[1]=1; count stays 2.
- Full queue, flush=1 with disp_valid=1 → next cycle count=0, issue_valid=0, disp_ready=1, no slot written by the dispatch.
- rst asserted asynchronously mid-cycle with count=3 → count=0 and all outputs at reset values before the next clock edge.
